// File: rtl/act_scheduler.sv
// -----------------------------------------------------------------------------
// act_scheduler
// Round-robin scheduler that shares one element-serial activation engine among
// NUM_REQ requesters. It arbitrates among pending requests, latches the
// winner's job descriptor, drives the engine enable/done handshake, guards each
// job with a watchdog and returns a one-cycle ack (plus err on failure).
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   req             per-requester job request, held until ack
//   req_func/base/len  packed per-requester descriptors, slice i = requester i
//   grant           one-hot owner of the engine while a job is in flight
//   ack, err        one-hot one-cycle job-complete / job-failed pulses
//   busy            high whenever the scheduler is not idle
//   eng_enable      level enable to the engine
//   eng_reset       one-cycle engine abort pulse on watchdog expiry
//   eng_func/base/len  latched descriptor of the current/last job
//   eng_done        engine completion level (stays high until next enable)
// All outputs are registered.
// -----------------------------------------------------------------------------
module act_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int FUNC_WIDTH = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*FUNC_WIDTH-1:0]    req_func,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               ack,
    output logic [NUM_REQ-1:0]               err,
    output logic                             busy,
    output logic                             eng_enable,
    output logic                             eng_reset,
    output logic [FUNC_WIDTH-1:0]            eng_func,
    output logic [ADDR_WIDTH-1:0]            eng_base,
    output logic [LEN_WIDTH-1:0]             eng_len,
    input  logic                             eng_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0]   PTR_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]    WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]    WD_ZERO  = WD_W'(0);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                state_r,    state_nxt_s;
    logic [IDX_W-1:0]      ptr_r,      ptr_nxt_s;
    logic [WD_W-1:0]       watchdog_r, watchdog_nxt_s;
    logic                  err_flag_r, err_flag_nxt_s;

    logic [NUM_REQ-1:0]    grant_nxt_s, ack_nxt_s, err_nxt_s;
    logic                  busy_nxt_s, enable_nxt_s, eng_reset_nxt_s;
    logic [FUNC_WIDTH-1:0] func_nxt_s;
    logic [ADDR_WIDTH-1:0] base_nxt_s;
    logic [LEN_WIDTH-1:0]  len_nxt_s;

    logic [NUM_REQ-1:0]    cand_s;
    logic                  win_found_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic [NUM_REQ-1:0]    win_onehot_s;
    logic [FUNC_WIDTH-1:0] win_func_s;
    logic [ADDR_WIDTH-1:0] win_base_s;
    logic [LEN_WIDTH-1:0]  win_len_s;

    // Requester index reached by stepping 'step' places past 'base', wrapping.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                   input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // The requester acked in this cycle still holds req; keep it out of the race.
    assign cand_s = req & ~ack;

    // Round-robin search starting just after the last winner; scanning the
    // farthest position first lets the nearest pending requester overwrite it.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = ptr_r;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (cand_s[rr_index(ptr_r, k)]) begin
                win_found_s = 1'b1;
                win_idx_s   = rr_index(ptr_r, k);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign win_onehot_s = ONE_HOT0 << win_idx_s;
    assign win_func_s   = req_func[win_idx_s*FUNC_WIDTH +: FUNC_WIDTH];
    assign win_base_s   = req_base[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len_s    = req_len[win_idx_s*LEN_WIDTH +: LEN_WIDTH];

    // Next-state and next-output logic of the job FSM.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        watchdog_nxt_s  = watchdog_r;
        err_flag_nxt_s  = err_flag_r;
        grant_nxt_s     = grant;
        ack_nxt_s       = '0;
        err_nxt_s       = '0;
        busy_nxt_s      = busy;
        enable_nxt_s    = eng_enable;
        eng_reset_nxt_s = 1'b0;
        func_nxt_s      = eng_func;
        base_nxt_s      = eng_base;
        len_nxt_s       = eng_len;

        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    ptr_nxt_s = win_idx_s;
                    if (win_len_s != '0) begin
                        grant_nxt_s    = win_onehot_s;
                        enable_nxt_s   = 1'b1;
                        busy_nxt_s     = 1'b1;
                        func_nxt_s     = win_func_s;
                        base_nxt_s     = win_base_s;
                        len_nxt_s      = win_len_s;
                        watchdog_nxt_s = WD_ZERO;
                        err_flag_nxt_s = 1'b0;
                        state_nxt_s    = ST_RUN;
                    end else begin
                        // Empty job: report it as failed without touching the engine.
                        ack_nxt_s = win_onehot_s;
                        err_nxt_s = win_onehot_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_RUN: begin
                watchdog_nxt_s = watchdog_r + WD_ONE;
                // watchdog == 0 marks the first RUN cycle, where eng_done may
                // still be the level left over from the previous job.
                if ((watchdog_r != WD_ZERO) && eng_done) begin
                    enable_nxt_s = 1'b0;
                    state_nxt_s  = ST_RELEASE;
                end else if (watchdog_r == WD_LAST) begin
                    enable_nxt_s    = 1'b0;
                    eng_reset_nxt_s = 1'b1;
                    err_flag_nxt_s  = 1'b1;
                    state_nxt_s     = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end

            ST_RELEASE: begin
                ack_nxt_s      = grant;
                err_nxt_s      = err_flag_r ? grant : '0;
                grant_nxt_s    = '0;
                busy_nxt_s     = 1'b0;
                err_flag_nxt_s = 1'b0;
                state_nxt_s    = ST_IDLE;
            end

            default: begin
                state_nxt_s  = ST_IDLE;
                grant_nxt_s  = '0;
                busy_nxt_s   = 1'b0;
                enable_nxt_s = 1'b0;
            end
        endcase
    end

    // State, pointer, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_INIT;
            watchdog_r <= WD_ZERO;
            err_flag_r <= 1'b0;
            grant      <= '0;
            ack        <= '0;
            err        <= '0;
            busy       <= 1'b0;
            eng_enable <= 1'b0;
            eng_reset  <= 1'b0;
            eng_func   <= '0;
            eng_base   <= '0;
            eng_len    <= '0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            watchdog_r <= watchdog_nxt_s;
            err_flag_r <= err_flag_nxt_s;
            grant      <= grant_nxt_s;
            ack        <= ack_nxt_s;
            err        <= err_nxt_s;
            busy       <= busy_nxt_s;
            eng_enable <= enable_nxt_s;
            eng_reset  <= eng_reset_nxt_s;
            eng_func   <= func_nxt_s;
            eng_base   <= base_nxt_s;
            eng_len    <= len_nxt_s;
        end
    end

endmodule

// File: tb/tb_act_scheduler.sv
// -----------------------------------------------------------------------------
// tb_act_scheduler
// Directed bench for act_scheduler. A default instance covers single job,
// round-robin order, stale done, zero length and reset mid-job; a second
// instance with TIMEOUT=8 covers the watchdog abort and done/timeout priority.
// -----------------------------------------------------------------------------
module tb_act_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, req_t;
    logic [7:0]  req_func;
    logic [39:0] req_base;
    logic [31:0] req_len;
    logic        eng_done, done_t;

    logic [3:0]  grant, ack, err;
    logic        busy, eng_enable, eng_reset;
    logic [1:0]  eng_func;
    logic [9:0]  eng_base;
    logic [7:0]  eng_len;

    logic [3:0]  grant_t, ack_t, err_t;
    logic        busy_t, en_t, rst_t;
    logic [1:0]  func_t;
    logic [9:0]  base_t;
    logic [7:0]  len_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    act_scheduler dut (
        .clk(clk), .reset(reset), .req(req),
        .req_func(req_func), .req_base(req_base), .req_len(req_len),
        .grant(grant), .ack(ack), .err(err), .busy(busy),
        .eng_enable(eng_enable), .eng_reset(eng_reset),
        .eng_func(eng_func), .eng_base(eng_base), .eng_len(eng_len),
        .eng_done(eng_done)
    );

    act_scheduler #(.TIMEOUT(8)) dut_t (
        .clk(clk), .reset(reset), .req(req_t),
        .req_func(req_func), .req_base(req_base), .req_len(req_len),
        .grant(grant_t), .ack(ack_t), .err(err_t), .busy(busy_t),
        .eng_enable(en_t), .eng_reset(rst_t),
        .eng_func(func_t), .eng_base(base_t), .eng_len(len_t),
        .eng_done(done_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a granted job on the default instance: done rises in the 2nd RUN cycle.
    task automatic serve(input string tag, input logic [3:0] who);
        eng_done = 1'b0;
        tick();
        check({tag, "_en_run"}, 32'(eng_enable), 32'd1);
        eng_done = 1'b1;
        tick();
        check({tag, "_en_rel"}, 32'(eng_enable), 32'd0);
        check({tag, "_noack_rel"}, 32'(ack), 32'd0);
        tick();
        check({tag, "_ack"}, 32'(ack), 32'(who));
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_gnt_off"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int drops;
        reset    = 1'b1;
        req      = 4'b0000;
        req_t    = 4'b0000;
        eng_done = 1'b0;
        done_t   = 1'b0;
        req_func = {2'd3, 2'd2, 2'd1, 2'd0};
        req_base = {10'h3AA, 10'h2BB, 10'h155, 10'h011};
        req_len  = {8'd7, 8'd9, 8'd16, 8'd5};
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(eng_enable), 32'd0);
        check("rst_engrst", 32'(eng_reset), 32'd0);
        check("rst_desc", {eng_func, eng_base, eng_len}, 32'd0);
        reset = 1'b0;

        // Single job on requester 1, done 18 cycles after enable.
        req = 4'b0010;
        tick();
        check("single_grant", 32'(grant), 32'h2);
        check("single_en", 32'(eng_enable), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        check("single_len", 32'(eng_len), 32'd16);
        check("single_func", 32'(eng_func), 32'd1);
        check("single_base", 32'(eng_base), 32'h155);
        drops = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (eng_enable !== 1'b1 || ack !== 4'b0000) drops++;
        end
        check("single_hold", 32'(drops), 32'd0);
        eng_done = 1'b1;
        tick();
        check("single_en_fall", 32'(eng_enable), 32'd0);
        check("single_grant_rel", 32'(grant), 32'h2);
        tick();
        check("single_ack", 32'(ack), 32'h2);
        check("single_err", 32'(err), 32'd0);
        check("single_busy_off", 32'(busy), 32'd0);
        req = 4'b0000;
        tick();
        check("single_ack_1cyc", 32'(ack), 32'd0);
        check("single_len_hold", 32'(eng_len), 32'd16);

        // Round-robin from a fresh reset with all four requesting.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        tick();
        check("rr_g0", 32'(grant), 32'h1);
        serve("rr0", 4'b0001);
        req = 4'b1110;
        tick();
        check("rr_g1", 32'(grant), 32'h2);
        serve("rr1", 4'b0010);
        req = 4'b1100;
        tick();
        check("rr_g2", 32'(grant), 32'h4);
        serve("rr2", 4'b0100);
        req = 4'b1000;
        tick();
        check("rr_g3", 32'(grant), 32'h8);
        serve("rr3", 4'b1000);
        req = 4'b0001;
        tick();
        check("rr_regrant0", 32'(grant), 32'h1);

        // Stale done: eng_done still high from the previous job at this grant.
        tick();
        check("stale_en", 32'(eng_enable), 32'd1);
        check("stale_busy", 32'(busy), 32'd1);
        eng_done = 1'b0;
        tick();
        check("stale_en2", 32'(eng_enable), 32'd1);
        tick();
        eng_done = 1'b1;
        tick();
        check("stale_en_fall", 32'(eng_enable), 32'd0);
        tick();
        check("stale_ack", 32'(ack), 32'h1);
        req = 4'b0000;

        // Zero-length job on requester 2, req held through its ack cycle.
        req_len = {8'd7, 8'd0, 8'd16, 8'd5};
        req = 4'b0100;
        tick();
        check("zl_ack", 32'(ack), 32'h4);
        check("zl_err", 32'(err), 32'h4);
        check("zl_en", 32'(eng_enable), 32'd0);
        check("zl_grant", 32'(grant), 32'd0);
        check("zl_busy", 32'(busy), 32'd0);
        tick();
        check("zl_mask_ack", 32'(ack), 32'd0);
        check("zl_mask_err", 32'(err), 32'd0);
        // Pointer now at 2: search order 3,0,1 picks requester 0.
        req = 4'b0011;
        tick();
        check("zl_ptr_grant", 32'(grant), 32'h1);
        serve("zl_next", 4'b0001);
        req = 4'b0000;
        req_len = {8'd7, 8'd9, 8'd16, 8'd5};
        tick();

        // Watchdog abort on the TIMEOUT=8 instance, engine never done.
        req_t = 4'b0010;
        tick();
        check("to_grant", 32'(grant_t), 32'h2);
        req_t = 4'b0000;
        drops = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (en_t !== 1'b1 || rst_t !== 1'b0) drops++;
        end
        check("to_hold", 32'(drops), 32'd0);
        tick();
        check("to_en_fall", 32'(en_t), 32'd0);
        check("to_engrst", 32'(rst_t), 32'd1);
        check("to_noack", 32'(ack_t), 32'd0);
        tick();
        check("to_engrst_1cyc", 32'(rst_t), 32'd0);
        check("to_ack", 32'(ack_t), 32'h2);
        check("to_err", 32'(err_t), 32'h2);
        tick();
        check("to_ack_1cyc", 32'(ack_t), 32'd0);

        // Done arriving in the last watchdog cycle wins over the timeout.
        req_t = 4'b1000;
        tick();
        check("tod_grant", 32'(grant_t), 32'h8);
        req_t = 4'b0000;
        for (int i = 0; i < 7; i++) tick();
        done_t = 1'b1;
        tick();
        check("tod_en_fall", 32'(en_t), 32'd0);
        check("tod_no_engrst", 32'(rst_t), 32'd0);
        tick();
        check("tod_ack", 32'(ack_t), 32'h8);
        check("tod_err", 32'(err_t), 32'd0);
        done_t = 1'b0;

        // Reset in the middle of a job on requester 2.
        req = 4'b0100;
        tick();
        check("mr_grant", 32'(grant), 32'h4);
        req = 4'b1111;
        tick();
        reset = 1'b1;
        tick();
        check("mr_grant0", 32'(grant), 32'd0);
        check("mr_busy0", 32'(busy), 32'd0);
        check("mr_en0", 32'(eng_enable), 32'd0);
        check("mr_ack0", 32'(ack), 32'd0);
        check("mr_len0", 32'(eng_len), 32'd0);
        reset = 1'b0;
        tick();
        check("mr_regrant", 32'(grant), 32'h1);
        check("mr_noack", 32'(ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
